// File: rtl/uart_fifo_bridge.sv
// UART echo bridge: a receiver feeds a FIFO that a transmitter drains back onto the line.
//
// Optional build macro: UART_FIFO_BRIDGE_PARITY_EN adds an even-parity bit after the data
// in both directions and exposes the sticky parity_err flag.
//
// Ports:
//   clk        - sole clock, rising edge
//   reset      - asynchronous active-low reset
//   rx         - serial input, asynchronous to clk
//   tx         - serial output, idle high
//   echo_en    - high: valid received words enter the FIFO; low: dropped
//   clr_err    - one-cycle pulse clearing the sticky error flags
//   busy       - transmitter not idle
//   fifo_count - current FIFO occupancy
//   overflow   - sticky, a word was lost because the FIFO was full
//   frame_err  - sticky, a stop bit was sampled low
//   parity_err - sticky, received parity mismatch (parity build only)
module uart_fifo_bridge #(
  parameter int unsigned IN_FREQ    = 220052,
  parameter int unsigned OUT_FREQ   = 96,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx,
  output logic                          tx,
  input  logic                          echo_en,
  input  logic                          clr_err,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          frame_err
`ifdef UART_FIFO_BRIDGE_PARITY_EN
  ,
  output logic                          parity_err
`endif
);

  localparam int unsigned Div = IN_FREQ / OUT_FREQ;
`ifdef UART_FIFO_BRIDGE_PARITY_EN
  localparam int unsigned ParBits = 1;
`else
  localparam int unsigned ParBits = 0;
`endif
  // Bits shifted per frame between start and stop (data plus optional parity).
  localparam int unsigned FrmBits = DATA_BITS + ParBits;
  localparam int unsigned CntW    = $clog2(Div);
  localparam int unsigned BitW    = $clog2(FrmBits);
  localparam int unsigned AddrW   = $clog2(FIFO_DEPTH);

  localparam logic [CntW-1:0] BitEnd  = CntW'(Div - 1);
  localparam logic [CntW-1:0] HalfEnd = CntW'(Div / 2 - 1);
  localparam logic [BitW-1:0] LastBit = BitW'(FrmBits - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  // ---------------------------------------------------------------------------
  // rx synchroniser
  // ---------------------------------------------------------------------------
  logic rx_meta_q, rx_sync_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------
  state_e               rx_state_q, rx_state_d;
  logic [CntW-1:0]      rx_cnt_q, rx_cnt_d;
  logic [BitW-1:0]      rx_bit_q, rx_bit_d;
  logic [FrmBits-1:0]   rx_shift_q, rx_shift_d;
  logic                 rx_brk_q, rx_brk_d;  // bad stop seen, waiting for line to go high
  logic                 rx_valid;
  logic                 frame_set;
`ifdef UART_FIFO_BRIDGE_PARITY_EN
  logic                 parity_set;
`endif

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_brk_d   = rx_brk_q;
    rx_valid   = 1'b0;
    frame_set  = 1'b0;
`ifdef UART_FIFO_BRIDGE_PARITY_EN
    parity_set = 1'b0;
`endif
    unique case (rx_state_q)
      StIdle: begin
        rx_cnt_d = '0;
        if (!rx_sync_q) rx_state_d = StStart;
      end
      StStart: begin
        if (rx_cnt_q == HalfEnd) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          // Line back high at mid-start: treat as a glitch.
          rx_state_d = rx_sync_q ? StIdle : StData;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      StData: begin
        if (rx_cnt_q == BitEnd) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[FrmBits-1:1]};
          if (rx_bit_q == LastBit) rx_state_d = StStop;
          else                     rx_bit_d   = rx_bit_q + 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      StStop: begin
        if (rx_brk_q) begin
          if (rx_sync_q) begin
            rx_brk_d   = 1'b0;
            rx_state_d = StIdle;
          end
        end else if (rx_cnt_q == BitEnd) begin
          rx_cnt_d = '0;
          if (!rx_sync_q) begin
            frame_set = 1'b1;
            rx_brk_d  = 1'b1;
          end else begin
            rx_state_d = StIdle;
`ifdef UART_FIFO_BRIDGE_PARITY_EN
            // Even parity: XOR over data and parity bit must be zero.
            if (^rx_shift_q) parity_set = 1'b1;
            else             rx_valid   = 1'b1;
`else
            rx_valid = 1'b1;
`endif
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state_q <= StIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_brk_q   <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_brk_q   <= rx_brk_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AddrW-1:0]     wptr_q, rptr_q;
  logic [AddrW:0]       count_q, count_d;
  logic                 fifo_full, fifo_empty, fifo_wr, fifo_rd, ovf_set;

  assign fifo_full  = (count_q == (AddrW + 1)'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the write.
  assign fifo_wr    = rx_valid & echo_en & (~fifo_full | fifo_rd);
  assign ovf_set    = rx_valid & echo_en & fifo_full & ~fifo_rd;

  always_comb begin
    count_d = count_q;
    unique case ({fifo_wr, fifo_rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (fifo_wr) wptr_q <= wptr_q + 1'b1;
      if (fifo_rd) rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_wr) mem_q[wptr_q] <= rx_shift_q[DATA_BITS-1:0];
  end

  assign fifo_count = count_q;

  // ---------------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------------
  state_e               tx_state_q, tx_state_d;
  logic [CntW-1:0]      tx_cnt_q, tx_cnt_d;
  logic [BitW-1:0]      tx_bit_q, tx_bit_d;
  logic [FrmBits-1:0]   tx_shift_q, tx_shift_d;
  logic [FrmBits-1:0]   tx_load;
  logic [DATA_BITS-1:0] head;

  assign head = mem_q[rptr_q];
`ifdef UART_FIFO_BRIDGE_PARITY_EN
  assign tx_load = {^head, head};
`else
  assign tx_load = head;
`endif

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    fifo_rd    = 1'b0;
    unique case (tx_state_q)
      StIdle: begin
        tx_cnt_d = '0;
        if (!fifo_empty) begin
          fifo_rd    = 1'b1;
          tx_shift_d = tx_load;
          tx_state_d = StStart;
        end
      end
      StStart: begin
        if (tx_cnt_q == BitEnd) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = StData;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      StData: begin
        if (tx_cnt_q == BitEnd) begin
          tx_cnt_d   = '0;
          tx_shift_d = {1'b1, tx_shift_q[FrmBits-1:1]};
          if (tx_bit_q == LastBit) tx_state_d = StStop;
          else                     tx_bit_d   = tx_bit_q + 1'b1;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      StStop: begin
        if (tx_cnt_q == BitEnd) begin
          tx_cnt_d   = '0;
          tx_state_d = StIdle;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: tx_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state_q <= StIdle;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
    end
  end

  // Decoded from state so reset forces the line high without waiting for a clock.
  always_comb begin
    tx = 1'b1;
    unique case (tx_state_q)
      StStart: tx = 1'b0;
      StData:  tx = tx_shift_q[0];
      default: tx = 1'b1;
    endcase
  end

  assign busy = (tx_state_q != StIdle);

  // ---------------------------------------------------------------------------
  // Sticky error flags (a new event wins over clr_err)
  // ---------------------------------------------------------------------------
  logic overflow_q, frame_err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      overflow_q  <= ovf_set   | (overflow_q  & ~clr_err);
      frame_err_q <= frame_set | (frame_err_q & ~clr_err);
    end
  end

  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;

`ifdef UART_FIFO_BRIDGE_PARITY_EN
  logic parity_err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) parity_err_q <= 1'b0;
    else        parity_err_q <= parity_set | (parity_err_q & ~clr_err);
  end

  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Testbench for uart_fifo_bridge: drives serial frames on rx, decodes tx with an
// independent line monitor and compares against a queue-based reference model.
module tb_uart_fifo_bridge;

  localparam int DIV = 20;
`ifdef UART_FIFO_BRIDGE_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif
  localparam int FRAME = (NB + 2) * DIV;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx = 1'b1;
  logic       echo_en = 1'b0;
  logic       clr_err = 1'b0;
  logic       tx, busy, overflow, frame_err;
  logic [2:0] fifo_count;
`ifdef UART_FIFO_BRIDGE_PARITY_EN
  logic       parity_err;
`endif

  uart_fifo_bridge #(
    .IN_FREQ   (20),
    .OUT_FREQ  (1),
    .DATA_BITS (8),
    .FIFO_DEPTH(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .tx        (tx),
    .echo_en   (echo_en),
    .clr_err   (clr_err),
    .busy      (busy),
    .fifo_count(fifo_count),
    .overflow  (overflow),
    .frame_err (frame_err)
`ifdef UART_FIFO_BRIDGE_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  out_q[$];
  logic [7:0]  exp_q[$];
  int unsigned start_cyc[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Line monitor: samples tx at mid-bit on the falling clock edge.
  initial begin : monitor
    logic [8:0]  w;
    bit          ok;
    int unsigned t0;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && tx === 1'b0) begin
        t0 = cyc;
        ok = 1'b1;
        w  = '0;
        repeat (DIV / 2 - 1) begin
          @(negedge clk);
          if (reset !== 1'b1) ok = 1'b0;
        end
        if (ok) check("tx start bit", tx, 0);
        for (int i = 0; i < NB; i++) begin
          repeat (DIV) begin
            @(negedge clk);
            if (reset !== 1'b1) ok = 1'b0;
          end
          w[i] = tx;
        end
        repeat (DIV) begin
          @(negedge clk);
          if (reset !== 1'b1) ok = 1'b0;
        end
        if (ok) begin
          check("tx stop bit", tx, 1);
`ifdef UART_FIFO_BRIDGE_PARITY_EN
          check("tx even parity", ^w, 0);
`endif
          out_q.push_back(w[7:0]);
          start_cyc.push_back(t0);
        end
      end
    end
  end

  // Drive one frame on rx starting at a falling edge.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop_val,
                            input int stop_len);
    rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (DIV) @(negedge clk);
    end
`ifdef UART_FIFO_BRIDGE_PARITY_EN
    rx = par;
    repeat (DIV) @(negedge clk);
`else
    if (par === 1'bx) rx = 1'b1;  // parity argument unused without the parity bit
`endif
    rx = stop_val;
    repeat (stop_len) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    repeat (4) @(negedge clk);
    while ((busy !== 1'b0 || fifo_count !== 3'd0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("drain finished", {busy, fifo_count}, 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic compare_out(input string tag);
    int n;
    check({tag, " count"}, out_q.size(), exp_q.size());
    n = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, " byte"}, out_q[i], exp_q[i]);
    out_q.delete();
    exp_q.delete();
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    @(negedge clk);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [7:0] b;
    logic [7:0] sent[$];
    int         n, j, matched;
    bit         seen_a, seen_b;

    // Reset state, checked without any clock edge.
    #3;
    check("rst tx", tx, 1);
    check("rst busy", busy, 0);
    check("rst fifo_count", fifo_count, 0);
    check("rst overflow", overflow, 0);
    check("rst frame_err", frame_err, 0);
`ifdef UART_FIFO_BRIDGE_PARITY_EN
    check("rst parity_err", parity_err, 0);
`endif
    @(negedge clk);
    reset = 1'b1;
    echo_en = 1'b1;
    repeat (3) @(negedge clk);

    // Single frame 0x8E: occupancy pulses to 1 for one cycle, busy lasts one frame.
    fork
      send_frame(8'h8E, ^8'h8E, 1'b1, DIV);
      begin
        n = 0;
        while (fifo_count === 3'd0 && n < 400) begin
          @(negedge clk);
          n++;
        end
        check("8E fifo_count first", fifo_count, 1);
        @(negedge clk);
        check("8E fifo_count popped", fifo_count, 0);
        n = 0;
        while (busy === 1'b1 && n < 1000) begin
          n++;
          @(negedge clk);
        end
        check("8E busy cycles", n, FRAME);
      end
    join
    exp_q.push_back(8'h8E);
    drain();
    compare_out("8E");

    // Short low glitch on rx is rejected.
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    seen_a = 1'b0;
    seen_b = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (busy) seen_a = 1'b1;
      if (fifo_count != 0) seen_b = 1'b1;
    end
    check("glitch busy", seen_a, 0);
    check("glitch fifo write", seen_b, 0);
    check("glitch frame_err", frame_err, 0);
    b = 8'($urandom);
    send_frame(b, ^b, 1'b1, DIV);
    exp_q.push_back(b);
    drain();
    compare_out("after glitch");

    // Random bytes with random echo_en.
    for (int k = 0; k < 8; k++) begin
      b = 8'($urandom);
      echo_en = 1'($urandom_range(0, 1));
      send_frame(b, ^b, 1'b1, DIV);
      if (echo_en) exp_q.push_back(b);
      drain();
    end
    compare_out("random");
    check("random frame_err", frame_err, 0);
    check("random overflow", overflow, 0);

    // Back-to-back: the second frame starts one idle cycle after the first ends.
    echo_en = 1'b1;
    start_cyc.delete();
    for (int k = 0; k < 2; k++) begin
      b = 8'($urandom);
      send_frame(b, ^b, 1'b1, 13);
      exp_q.push_back(b);
    end
    drain();
    check("b2b frames", start_cyc.size(), 2);
    if (start_cyc.size() == 2) check("b2b gap", start_cyc[1] - start_cyc[0], FRAME + 1);
    compare_out("b2b");

    // Bad stop bit: flagged, word discarded, next frame fine.
    send_frame(8'h55, ^8'h55, 1'b0, DIV);
    repeat (20) @(negedge clk);
    check("ferr set", frame_err, 1);
    check("ferr no write", fifo_count, 0);
    send_frame(8'hAA, ^8'hAA, 1'b1, DIV);
    exp_q.push_back(8'hAA);
    drain();
    compare_out("ferr");
    check("ferr sticky", frame_err, 1);
    pulse_clr();
    check("ferr cleared", frame_err, 0);

    // Overflow: short-stop frames arrive slightly faster than tx drains.
    sent.delete();
    n = 0;
    while (overflow !== 1'b1 && n < 250) begin
      b = 8'($urandom);
      send_frame(b, ^b, 1'b1, 13);
      sent.push_back(b);
      n++;
    end
    check("ovf set", overflow, 1);
    drain();
    j = 0;
    matched = 0;
    foreach (out_q[i]) begin
      while (j < sent.size() && sent[j] != out_q[i]) j++;
      if (j < sent.size()) begin
        matched++;
        j++;
      end
    end
    check("ovf in-order subset", matched, out_q.size());
    check("ovf words lost", out_q.size() < sent.size(), 1);
    out_q.delete();
    check("ovf sticky", overflow, 1);
    pulse_clr();
    check("ovf cleared", overflow, 0);

    // Reset in the middle of tx data bit 3 (bit 3 of 0x07 is 0).
    fork
      send_frame(8'h07, ^8'h07, 1'b1, DIV);
      begin
        n = 0;
        while (busy !== 1'b1 && n < 400) begin
          @(negedge clk);
          n++;
        end
        repeat (DIV * 4 + DIV / 2) @(negedge clk);
        check("pre-reset tx bit3", tx, 0);
        reset = 1'b0;
        #1;
        check("mid rst tx", tx, 1);
        check("mid rst busy", busy, 0);
        check("mid rst fifo_count", fifo_count, 0);
      end
    join
    repeat (3) @(negedge clk);
    reset = 1'b1;
    seen_a = 1'b0;
    repeat (600) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) seen_a = 1'b1;
    end
    check("post rst quiet", seen_a, 0);
    check("post rst no output", out_q.size(), 0);
    out_q.delete();

`ifdef UART_FIFO_BRIDGE_PARITY_EN
    send_frame(8'h07, 1'b0, 1'b1, DIV);
    repeat (20) @(negedge clk);
    check("par err set", parity_err, 1);
    check("par no write", fifo_count, 0);
    send_frame(8'h07, 1'b1, 1'b1, DIV);
    exp_q.push_back(8'h07);
    drain();
    compare_out("parity");
    pulse_clr();
    check("par cleared", parity_err, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
